// File: rtl/slow_memory_param.sv
// rtl/slow_memory_param.sv - line-granular backing memory with deterministic response latency
// Optional statistics outputs rd_cnt/wr_cnt/busy_cyc are built when SLOW_MEM_STATS_EN is defined.
module slow_memory_param #(
    parameter int LINE_W  = 128,
    parameter int ADDR_W  = 28,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              busy
`ifdef SLOW_MEM_STATS_EN
    ,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt,
    output logic [31:0]       busy_cyc
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                op_wr_q, op_wr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic [LINE_W-1:0]   mem [DEPTH];

    // Upper line-address bits alias onto the same lines.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[ADDR_W-1:IDX_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    op_wr_d = mem_write;
                    idx_d   = mem_addr[IDX_W-1:0];
                    wdata_d = mem_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Read data is captured on the edge entering RESP so it is stable for the whole pulse.
        if (state_d == RESP && state_q != RESP && !op_wr_d) begin
            rdata_d = mem[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is never reset; a reset before RESP leaves the pending write undone.
    always_ff @(posedge clk) begin
        if (state_q == RESP && op_wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = (state_q == RESP);
    assign busy      = (state_q != IDLE);

`ifdef SLOW_MEM_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q, busy_cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            busy_cyc_q <= '0;
        end else begin
            if (state_q == RESP && !op_wr_q && rd_cnt_q != '1) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (state_q == RESP && op_wr_q && wr_cnt_q != '1) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
            if (state_q != IDLE && busy_cyc_q != '1) begin
                busy_cyc_q <= busy_cyc_q + 32'd1;
            end
        end
    end

    assign rd_cnt   = rd_cnt_q;
    assign wr_cnt   = wr_cnt_q;
    assign busy_cyc = busy_cyc_q;
`endif

endmodule

// File: tb/tb_slow_memory_param.sv
// tb/tb_slow_memory_param.sv - checks slow_memory_param (LATENCY 8 and 1) against a line-array model
module tb_slow_memory_param;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         m0_read, m0_write, m1_read, m1_write;
    logic [27:0]  m0_addr, m1_addr;
    logic [127:0] m0_wdata, m1_wdata;
    logic [127:0] m0_rdata, m1_rdata;
    logic         m0_ready, m1_ready, m0_busy, m1_busy;
`ifdef SLOW_MEM_STATS_EN
    logic [31:0]  m0_rd_cnt, m0_wr_cnt, m0_busy_cyc;
    logic [31:0]  m1_rd_cnt, m1_wr_cnt, m1_busy_cyc;
`endif

    int errors = 0;
    int checks = 0;
    logic [127:0] model [256];
    logic [127:0] last_rdata;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp_rdata;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    slow_memory_param #(.LINE_W(128), .ADDR_W(28), .DEPTH(256), .LATENCY(8)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(m0_read), .mem_write(m0_write),
        .mem_addr(m0_addr), .mem_wdata(m0_wdata), .mem_rdata(m0_rdata),
        .mem_ready(m0_ready), .busy(m0_busy)
`ifdef SLOW_MEM_STATS_EN
        , .rd_cnt(m0_rd_cnt), .wr_cnt(m0_wr_cnt), .busy_cyc(m0_busy_cyc)
`endif
    );

    slow_memory_param #(.LINE_W(128), .ADDR_W(28), .DEPTH(256), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(m1_read), .mem_write(m1_write),
        .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_rdata(m1_rdata),
        .mem_ready(m1_ready), .busy(m1_busy)
`ifdef SLOW_MEM_STATS_EN
        , .rd_cnt(m1_rd_cnt), .wr_cnt(m1_wr_cnt), .busy_cyc(m1_busy_cyc)
`endif
    );

    task automatic chk_val(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int s);
        return (s == 0) ? m0_ready : m1_ready;
    endfunction

    function automatic logic bsy(input int s);
        return (s == 0) ? m0_busy : m1_busy;
    endfunction

    function automatic logic [127:0] rdat(input int s);
        return (s == 0) ? m0_rdata : m1_rdata;
    endfunction

    task automatic drive(input int s, input logic rd, input logic wr,
                         input logic [27:0] a, input logic [127:0] d);
        if (s == 0) begin
            m0_read = rd; m0_write = wr; m0_addr = a; m0_wdata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_addr = a; m1_wdata = d;
        end
    endtask

    // One cache-style access: request held until mem_ready is seen, then dropped.
    task automatic txn(input int s, input logic rd, input logic wr, input logic [27:0] a,
                       input logic [127:0] d, input bit chk, output logic [127:0] rd_out);
        int exp_cyc;
        int cyc;
        int busy_bad;
        bit got;
        exp_cyc  = (s == 0) ? 9 : 1;
        cyc      = 0;
        busy_bad = 0;
        got      = 1'b0;
        @(negedge clk);
        drive(s, rd, wr, a, d);
        while (!got && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!bsy(s)) busy_bad++;
            if (rdy(s)) got = 1'b1;
        end
        rd_out = rdat(s);
        drive(s, 1'b0, 1'b0, '0, '0);
        if (chk) begin
            chk_int("latency", cyc, exp_cyc);
            chk_int("busy_during_access", busy_bad, 0);
        end
        @(posedge clk);
        #1;
        if (chk) chk_int("ready_pulse_then_idle", {30'd0, rdy(s), bsy(s)}, 0);
        if (s == 0 && wr) model[a[7:0]] = d;
    endtask

    initial begin
        logic [127:0] r;
        logic [127:0] exp;
        logic [127:0] old9;
        int c1, c2, cyc, idle_after, ready_seen;
        logic rd, wr;
        logic [27:0] a;
        logic [127:0] d;
        int op;

        tbl[0] = '{1'b1, 1'b0, 28'h0000005, 128'h0,      128'hDEAD};
        tbl[1] = '{1'b0, 1'b1, 28'h0000003, 128'h1234,   128'hDEAD};
        tbl[2] = '{1'b1, 1'b0, 28'h0000003, 128'h0,      128'h1234};
        tbl[3] = '{1'b0, 1'b1, 28'h0000105, 128'h55AA55, 128'h1234};
        tbl[4] = '{1'b1, 1'b0, 28'h0000005, 128'h0,      128'h55AA55};
        tbl[5] = '{1'b1, 1'b1, 28'h0000007, 128'hAA,     128'h55AA55};
        tbl[6] = '{1'b1, 1'b0, 28'h0000007, 128'h0,      128'hAA};

        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk_val("reset_rdata", m0_rdata, '0);
        chk_int("reset_ready_busy", {30'd0, m0_ready, m0_busy}, 0);
        chk_int("reset_ready_busy_lat1", {30'd0, m1_ready, m1_busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Preload through the write port; mem[5] gets the known line.
        for (int i = 0; i < 256; i++) begin
            d = (i == 5) ? 128'hDEAD : {$urandom, $urandom, $urandom, $urandom};
            txn(0, 1'b0, 1'b1, 28'(i), d, 1'b0, r);
        end
        txn(1, 1'b0, 1'b1, 28'h2, 128'hC0FFEE, 1'b1, r);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        txn(1, 1'b1, 1'b0, 28'h2, '0, 1'b1, r);
        chk_val("lat1_read_data", r, 128'hC0FFEE);
`ifdef SLOW_MEM_STATS_EN
        chk_int("lat1_rd_cnt", int'(m1_rd_cnt), 1);
        chk_int("lat1_wr_cnt", int'(m1_wr_cnt), 0);
        chk_int("lat1_busy_cyc", int'(m1_busy_cyc), 1);
`endif

        for (int i = 0; i < 7; i++) begin
            txn(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b1, r);
            chk_val($sformatf("table_rdata_%0d", i), r, tbl[i].exp_rdata);
        end

        // Read held across mem_ready: next sample only happens after an IDLE cycle.
        c1 = 0; c2 = 0; cyc = 0; idle_after = 0;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 28'h3, '0);
        while (c2 == 0 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (m0_ready) begin
                if (c1 == 0) c1 = cyc; else c2 = cyc;
            end
            if (c1 != 0 && cyc == c1 + 1 && !m0_busy && !m0_ready) idle_after = 1;
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        chk_int("held_first_pulse", c1, 9);
        chk_int("held_pulse_interval", c2 - c1, 10);
        chk_int("held_idle_gap", idle_after, 1);
        chk_val("held_rdata", m0_rdata, 128'h1234);
        last_rdata = 128'h1234;
        @(posedge clk);

        // Reset during WAIT of a write to line 9.
        old9 = model[9];
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 28'h9, ~old9);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        #1;
        chk_val("midreset_rdata", m0_rdata, '0);
        chk_int("midreset_ready_busy", {30'd0, m0_ready, m0_busy}, 0);
        ready_seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (m0_ready) ready_seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (m0_ready) ready_seen++;
        end
        chk_int("midreset_no_ready", ready_seen, 0);
        txn(0, 1'b1, 1'b0, 28'h9, '0, 1'b1, r);
        chk_val("midreset_line_unchanged", r, old9);
        last_rdata = old9;

        for (int i = 0; i < 25; i++) begin
            op = int'($urandom_range(2, 0));
            rd = (op != 1);
            wr = (op != 0);
            a  = 28'($urandom);
            d  = {$urandom, $urandom, $urandom, $urandom};
            exp = wr ? last_rdata : model[a[7:0]];
            txn(0, rd, wr, a, d, 1'b1, r);
            chk_val($sformatf("random_rdata_%0d", i), r, exp);
            last_rdata = exp;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
